// File: rtl/radiant_ext_trig_tx_pkg.sv
// Shared types and defaults for the RADIANT external trigger transmitter.
// Holds the 2-bit FSM encoding, default field widths and a width helper.
package radiant_ext_trig_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_PULSE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } tx_state_e;

  localparam int DEF_DELAY_BITS   = 16;
  localparam int DEF_WIDTH_BITS   = 16;
  localparam int DEF_HOLDOFF_BITS = 16;
  localparam int DEF_CNT_BITS     = 32;

  // Width of the shared down-counter: wide enough for any of the three phases.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/radiant_ext_trig_tx.sv
// TRIGOUT transmitter: one delayed, fixed-width pulse per accepted request,
// followed by a holdoff; counts issued/dropped requests and latches on PPS.
module radiant_ext_trig_tx
  import radiant_ext_trig_tx_pkg::*;
#(
  parameter int DELAY_BITS   = DEF_DELAY_BITS,
  parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
  parameter int HOLDOFF_BITS = DEF_HOLDOFF_BITS,
  parameter int CNT_BITS     = DEF_CNT_BITS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    trig_i,
  input  logic [DELAY_BITS-1:0]   delay_i,
  input  logic [WIDTH_BITS-1:0]   width_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic                    invert_i,
  input  logic                    pps_i,
  output logic                    ext_trig_o,
  output logic                    busy_o,
  output logic                    accepted_o,
  output logic                    dropped_o,
  output logic [CNT_BITS-1:0]     count_o,
  output logic [CNT_BITS-1:0]     drop_count_o,
  output logic [CNT_BITS-1:0]     count_pps_o
);

  localparam int CW = max3(DELAY_BITS, WIDTH_BITS, HOLDOFF_BITS);
  localparam logic [CW-1:0]       CW_ONE  = CW'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  tx_state_e           state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       width_m1_q;
  logic [CW-1:0]       holdoff_q;
  logic                pulse_q;
  logic                accepted_q;
  logic                dropped_q;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_BITS-1:0] drop_count_q, drop_count_d;
  logic [CNT_BITS-1:0] count_pps_q, count_pps_d;

  logic [CW-1:0] delay_ext;
  logic [CW-1:0] width_ext;
  logic [CW-1:0] width_m1;
  logic [CW-1:0] holdoff_ext;
  logic          accept;
  logic          drop;

  always_comb begin
    delay_ext   = CW'(delay_i);
    width_ext   = CW'(width_i);
    holdoff_ext = CW'(holdoff_i);
    // A zero width still produces a single-cycle pulse.
    width_m1    = (width_ext == '0) ? '0 : width_ext - CW_ONE;
    accept      = trig_i && en_i && (state_q == ST_IDLE);
    drop        = trig_i && !accept;
  end

  always_comb begin
    count_d      = accept ? count_q + CNT_ONE : count_q;
    drop_count_d = (drop && (drop_count_q != '1)) ? drop_count_q + CNT_ONE : drop_count_q;
    // PPS snapshot takes the value before any same-cycle increment.
    count_pps_d  = pps_i ? count_q : count_pps_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      width_m1_q <= '0;
      holdoff_q  <= '0;
      pulse_q    <= 1'b0;
    end else if (!en_i) begin
      // Disabling aborts immediately; no holdoff is imposed afterwards.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            width_m1_q <= width_m1;
            holdoff_q  <= holdoff_ext;
            if (delay_ext != '0) begin
              state_q <= ST_DELAY;
              cnt_q   <= delay_ext - CW_ONE;
            end else begin
              state_q <= ST_PULSE;
              cnt_q   <= width_m1;
              pulse_q <= 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == '0) begin
            state_q <= ST_PULSE;
            cnt_q   <= width_m1_q;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            pulse_q <= 1'b0;
            if (holdoff_q != '0) begin
              state_q <= ST_HOLDOFF;
              cnt_q   <= holdoff_q - CW_ONE;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW_ONE;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CW_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      accepted_q   <= 1'b0;
      dropped_q    <= 1'b0;
      count_q      <= '0;
      drop_count_q <= '0;
      count_pps_q  <= '0;
    end else begin
      accepted_q   <= accept;
      dropped_q    <= drop;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
      count_pps_q  <= count_pps_d;
    end
  end

  // Polarity is applied after the register; invert_i is a static setting.
  assign ext_trig_o   = pulse_q ^ invert_i;
  assign busy_o       = (state_q != ST_IDLE) || !en_i;
  assign accepted_o   = accepted_q;
  assign dropped_o    = dropped_q;
  assign count_o      = count_q;
  assign drop_count_o = drop_count_q;
  assign count_pps_o  = count_pps_q;

endmodule

// File: tb/tb_radiant_ext_trig_tx.sv
// Bench for radiant_ext_trig_tx: directed scenarios plus a randomized run
// checked against a time-window model of the pulse/busy behaviour.
module tb_radiant_ext_trig_tx;

  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, trig = 1'b0, inv = 1'b0, pps = 1'b0;
  logic [15:0]   dly = '0, wid = '0, hold = '0;
  logic          ext, busy, acc, drp;
  logic [CB-1:0] cnt, dcnt, pcnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: last acceptance cycle, its settings, and last busy cycle.
  int m_acc_t, m_end, m_d, m_w, m_h, m_cnt, m_drop, m_pps;
  bit m_acc_flag, m_drop_flag;

  always #5 clk = ~clk;

  radiant_ext_trig_tx #(
    .DELAY_BITS(16), .WIDTH_BITS(16), .HOLDOFF_BITS(16), .CNT_BITS(CB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .trig_i(trig),
    .delay_i(dly), .width_i(wid), .holdoff_i(hold), .invert_i(inv), .pps_i(pps),
    .ext_trig_o(ext), .busy_o(busy), .accepted_o(acc), .dropped_o(drp),
    .count_o(cnt), .drop_count_o(dcnt), .count_pps_o(pcnt)
  );

  task automatic model_reset();
    m_acc_t = -1000; m_end = -1000; m_d = 0; m_w = 0; m_h = 0;
    m_cnt = 0; m_drop = 0; m_pps = 0; m_acc_flag = 0; m_drop_flag = 0;
  endtask

  task automatic model_step();
    bit idle, a;
    idle = (cyc > m_end);
    a = trig && en && idle;
    if (!en && !idle) m_end = cyc;
    if (pps) m_pps = m_cnt;
    if (a) begin
      m_acc_t = cyc;
      m_d = int'(dly);
      m_w = (wid == 16'd0) ? 1 : int'(wid);
      m_h = int'(hold);
      m_end = cyc + m_d + m_w + m_h;
      m_cnt = (m_cnt + 1) % (1 << CB);
      $display("[TB] cyc %0d trigger accepted D=%0d W=%0d H=%0d", cyc, m_d, m_w, m_h);
    end
    if (trig && !a && m_drop < (1 << CB) - 1) m_drop++;
    m_acc_flag  = a;
    m_drop_flag = trig && !a;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; trig = 1'b0; pps = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_cfg(input int d, input int w, input int h);
    dly = 16'(d); wid = 16'(w); hold = 16'(h);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; inv = 1'b0;
    #12;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_dis: got %b want 1", busy); end
    n_tests++; if (ext !== 1'b0) begin n_fail++; $display("FAIL reset_ext: got %b want 0", ext); end
    n_tests++; if (acc !== 1'b0 || drp !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", acc, drp); end
    n_tests++; if (cnt !== '0 || dcnt !== '0 || pcnt !== '0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", cnt, dcnt, pcnt); end
    en = 1'b1; #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_en: got %b want 0", busy); end
    inv = 1'b1; #1;
    n_tests++; if (ext !== 1'b1) begin n_fail++; $display("FAIL reset_ext_inv: got %b want 1", ext); end
    inv = 1'b0;
  endtask

  task automatic test_basic();
    do_reset(); set_cfg(0, 1, 0); en = 1'b1;
    trig = 1'b1; tick(); trig = 1'b0;
    n_tests++; if (ext !== 1'b1) begin n_fail++; $display("FAIL basic_c1_ext: got %b want 1", ext); end
    n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_c1_acc: got %b want 1", acc); end
    n_tests++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL basic_c1_count: got %0d want 1", cnt); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_c1_busy: got %b want 1", busy); end
    tick();
    n_tests++; if (ext !== 1'b0 || busy !== 1'b0 || acc !== 1'b0) begin n_fail++; $display("FAIL basic_c2: got ext/busy/acc %b%b%b want 000", ext, busy, acc); end
    trig = 1'b1; tick(); trig = 1'b0;
    n_tests++; if (acc !== 1'b1 || ext !== 1'b1 || cnt !== 4'd2) begin n_fail++; $display("FAIL basic_c3: got acc/ext/count %b/%b/%0d want 1/1/2", acc, ext, cnt); end
  endtask

  task automatic test_holdoff_drop();
    bit e_ext, e_acc, e_drp;
    do_reset(); set_cfg(3, 4, 5); en = 1'b1;
    for (int k = 0; k < 22; k++) begin
      trig = (k == 0 || k == 8 || k == 13);
      tick(); trig = 1'b0;
      e_ext = ((k + 1) >= 4 && (k + 1) <= 7) || ((k + 1) >= 17 && (k + 1) <= 20);
      e_acc = ((k + 1) == 1 || (k + 1) == 14);
      e_drp = ((k + 1) == 9);
      n_tests++; if (ext !== e_ext) begin n_fail++; $display("FAIL holdoff_ext c%0d: got %b want %b", k + 1, ext, e_ext); end
      n_tests++; if (acc !== e_acc) begin n_fail++; $display("FAIL holdoff_acc c%0d: got %b want %b", k + 1, acc, e_acc); end
      n_tests++; if (drp !== e_drp) begin n_fail++; $display("FAIL holdoff_drop c%0d: got %b want %b", k + 1, drp, e_drp); end
    end
    n_tests++; if (dcnt !== 4'd1 || cnt !== 4'd2) begin n_fail++; $display("FAIL holdoff_counts: got %0d/%0d want 2/1", cnt, dcnt); end
  endtask

  task automatic test_invert_width0();
    bit e_ext;
    inv = 1'b1; rst = 1'b1; #1;
    n_tests++; if (ext !== 1'b1) begin n_fail++; $display("FAIL inv_during_rst: got %b want 1", ext); end
    do_reset(); set_cfg(1, 0, 0); en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      trig = (k == 0);
      tick(); trig = 1'b0;
      e_ext = ((k + 1) != 2);
      n_tests++; if (ext !== e_ext) begin n_fail++; $display("FAIL inv_w0_ext c%0d: got %b want %b", k + 1, ext, e_ext); end
    end
    inv = 1'b0;
  endtask

  task automatic test_enable_abort();
    bit e_ext, e_acc, e_drp;
    do_reset(); set_cfg(2, 10, 3); en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      en   = !(k == 5 || k == 6);
      trig = (k == 0 || k == 6 || k == 7);
      tick(); trig = 1'b0;
      e_ext = ((k + 1) >= 3 && (k + 1) <= 5) || ((k + 1) >= 10);
      e_acc = ((k + 1) == 1 || (k + 1) == 8);
      e_drp = ((k + 1) == 7);
      n_tests++; if (ext !== e_ext) begin n_fail++; $display("FAIL abort_ext c%0d: got %b want %b", k + 1, ext, e_ext); end
      n_tests++; if (acc !== e_acc) begin n_fail++; $display("FAIL abort_acc c%0d: got %b want %b", k + 1, acc, e_acc); end
      n_tests++; if (drp !== e_drp) begin n_fail++; $display("FAIL abort_drop c%0d: got %b want %b", k + 1, drp, e_drp); end
    end
    en = 1'b1;
  endtask

  task automatic test_wrap_saturate();
    logic [CB-1:0] e;
    do_reset(); set_cfg(0, 1, 0); en = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      trig = 1'b1; tick(); trig = 1'b0;
      e = CB'(n % 16);
      n_tests++; if (cnt !== e) begin n_fail++; $display("FAIL wrap_count n%0d: got %0d want %0d", n, cnt, e); end
      tick();
    end
    en = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      trig = 1'b1; tick();
      e = CB'((n < 15) ? n : 15);
      n_tests++; if (dcnt !== e) begin n_fail++; $display("FAIL sat_drop n%0d: got %0d want %0d", n, dcnt, e); end
    end
    trig = 1'b0; en = 1'b1;
  endtask

  task automatic test_pps();
    do_reset(); set_cfg(0, 1, 0); en = 1'b1;
    for (int n = 0; n < 7; n++) begin
      trig = 1'b1; tick(); trig = 1'b0; tick();
    end
    trig = 1'b1; pps = 1'b1; tick(); trig = 1'b0; pps = 1'b0;
    n_tests++; if (pcnt !== 4'd7) begin n_fail++; $display("FAIL pps_coincident: got %0d want 7", pcnt); end
    n_tests++; if (cnt !== 4'd8) begin n_fail++; $display("FAIL pps_count: got %0d want 8", cnt); end
    tick(); pps = 1'b1; tick(); pps = 1'b0;
    n_tests++; if (pcnt !== 4'd8) begin n_fail++; $display("FAIL pps_plain: got %0d want 8", pcnt); end
  endtask

  task automatic test_async_reset();
    do_reset(); set_cfg(2, 10, 3); en = 1'b1;
    trig = 1'b1; tick(); trig = 1'b0;
    repeat (3) tick();
    n_tests++; if (ext !== 1'b1) begin n_fail++; $display("FAIL arst_pre_ext: got %b want 1", ext); end
    trig = 1'b1; tick(); trig = 1'b0;
    n_tests++; if (drp !== 1'b1 || cnt !== 4'd1) begin n_fail++; $display("FAIL arst_pre_state: got drop/count %b/%0d want 1/1", drp, cnt); end
    #3 rst = 1'b1;
    #1;
    n_tests++; if (ext !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_ext_busy: got %b%b want 00", ext, busy); end
    n_tests++; if (acc !== 1'b0 || drp !== 1'b0) begin n_fail++; $display("FAIL arst_flags: got %b%b want 00", acc, drp); end
    n_tests++; if (cnt !== '0 || dcnt !== '0 || pcnt !== '0) begin n_fail++; $display("FAIL arst_counts: got %0d/%0d/%0d want 0/0/0", cnt, dcnt, pcnt); end
    do_reset();
  endtask

  task automatic test_random();
    bit e_ext, e_busy;
    do_reset(); en = 1'b1; inv = 1'b0;
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 24) != 0);
      trig = ($urandom_range(0, 2) == 0);
      pps  = ($urandom_range(0, 15) == 0);
      dly  = 16'($urandom_range(0, 4));
      wid  = 16'($urandom_range(0, 4));
      hold = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) inv = ~inv;
      tick();
      e_ext  = ((cyc >= m_acc_t + m_d + 1) && (cyc <= m_acc_t + m_d + m_w) && (cyc <= m_end)) ^ inv;
      e_busy = ((cyc > m_acc_t) && (cyc <= m_end)) || !en;
      n_tests++; if (ext !== e_ext) begin n_fail++; $display("FAIL rnd_ext cyc%0d: got %b want %b", cyc, ext, e_ext); end
      n_tests++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy cyc%0d: got %b want %b", cyc, busy, e_busy); end
      n_tests++; if (acc !== m_acc_flag) begin n_fail++; $display("FAIL rnd_acc cyc%0d: got %b want %b", cyc, acc, m_acc_flag); end
      n_tests++; if (drp !== m_drop_flag) begin n_fail++; $display("FAIL rnd_drop cyc%0d: got %b want %b", cyc, drp, m_drop_flag); end
      n_tests++; if (cnt !== CB'(m_cnt)) begin n_fail++; $display("FAIL rnd_count cyc%0d: got %0d want %0d", cyc, cnt, m_cnt); end
      n_tests++; if (dcnt !== CB'(m_drop)) begin n_fail++; $display("FAIL rnd_dropcnt cyc%0d: got %0d want %0d", cyc, dcnt, m_drop); end
      n_tests++; if (pcnt !== CB'(m_pps)) begin n_fail++; $display("FAIL rnd_pps cyc%0d: got %0d want %0d", cyc, pcnt, m_pps); end
    end
    trig = 1'b0; pps = 1'b0; en = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_holdoff_drop();
    test_invert_width0();
    test_enable_abort();
    test_wrap_saturate();
    test_pps();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
